// File: rtl/step_motor_pkg.sv
// Shared definitions for the half-step motor sequencer: FSM encoding,
// phase-index width and the 8-entry half-step coil pattern.
package step_motor_pkg;

  localparam int unsigned PH_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Element [0] is the rightmost entry.
  localparam logic [7:0][3:0] HALF_STEP_TBL = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

endpackage

// File: rtl/step_phase_lut.sv
// Combinational phase index to coil pattern lookup for the half-step sequence.
module step_phase_lut
  import step_motor_pkg::*;
(
  input  logic [PH_W-1:0] idx_i,
  output logic [3:0]      pat_o
);

  assign pat_o = HALF_STEP_TBL[idx_i];

endmodule

// File: rtl/step_motor_sequencer.sv
// Command-driven half-step sequencer for a 4-phase unipolar stepper.
// Optional acceleration ramp is enabled by defining STEP_RAMP_EN.
//   state | meaning
//   IDLE  | waiting for a command, coils held or released per hold_en
//   RUN   | stepping, one half-step per effective period
//   FIN   | one-cycle done pulse, then back to IDLE
module step_motor_sequencer
  import step_motor_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PER_W = 24,
`ifdef STEP_RAMP_EN
  parameter logic [PER_W-1:0] RAMP_START = PER_W'(500000),
  parameter logic [PER_W-1:0] RAMP_DEC   = PER_W'(1000),
`endif
  parameter int unsigned POS_W = 16
) (
  input  logic             saatDarbesi,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             hold_en,
  output logic [3:0]       motorCikis,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [3:0]       motor_q, motor_d;
  logic [3:0]       pat;

  logic [PER_W-1:0] cmd_per_eff;
  logic [PER_W-1:0] start_per;
  logic [PER_W-1:0] next_per;
  logic             accept;
  logic             start_run;
  logic             step_due;

  assign cmd_per_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;
  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign start_run   = accept && (cmd_steps != '0);
  // Abort takes priority over a step falling due in the same cycle.
  assign step_due    = (state_q == ST_RUN) && !abort && (timer_q == PER_W'(1));

`ifdef STEP_RAMP_EN
  logic [PER_W-1:0] eff_q, eff_d, eff_dec;

  assign start_per = (RAMP_START > cmd_per_eff) ? RAMP_START : cmd_per_eff;
  assign eff_dec   = (eff_q > RAMP_DEC) ? (eff_q - RAMP_DEC) : '0;
  assign next_per  = (eff_dec > per_q) ? eff_dec : per_q;

  always_comb begin
    eff_d = eff_q;
    if (start_run)     eff_d = start_per;
    else if (step_due) eff_d = next_per;
  end

  always_ff @(posedge saatDarbesi or posedge rst) begin
    if (rst) eff_q <= '0;
    else     eff_q <= eff_d;
  end
`else
  assign start_per = cmd_per_eff;
  assign next_per  = per_q;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    per_d   = per_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dir_d = cmd_dir;
          per_d = cmd_per_eff;
          rem_d = cmd_steps;
          if (cmd_steps == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            timer_d = start_per;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_FIN;
        end else if (step_due) begin
          phase_d = dir_q ? (phase_q - PH_W'(1)) : (phase_q + PH_W'(1));
          pos_d   = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
          rem_d   = rem_q - CNT_W'(1);
          timer_d = next_per;
          if (rem_q == CNT_W'(1)) state_d = ST_FIN;
        end else begin
          timer_d = timer_q - PER_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One lookup on the next phase serves both the run and idle-hold paths.
  step_phase_lut u_lut (
    .idx_i (phase_d),
    .pat_o (pat)
  );

  always_comb begin
    motor_d = 4'b0000;
    if ((state_q == ST_RUN) || start_run || hold_en) motor_d = pat;
  end

  always_ff @(posedge saatDarbesi or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      timer_q <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      motor_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      motor_q <= motor_d;
    end
  end

  assign motorCikis = motor_q;
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_FIN);
  assign position   = pos_q;

endmodule
